// File: rtl/extbus_cycle_master.sv
// extbus_cycle_master: command-driven 6502-style phi2 bus cycle generator with repeats, gaps and read compare
module extbus_cycle_master #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter int                HALF_PER = 3,
   parameter int                T_AH     = 1,
   parameter logic [ADDR_W-1:0] CS_BASE  = 16'h9F20,
   parameter logic [ADDR_W-1:0] CS_MASK  = 16'hFFE0,
   parameter int                REP_W    = 8,
   parameter int                GAP_W    = 24
) (
   input  logic              clk25,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [DATA_W-1:0] cmd_step,
   input  logic [REP_W-1:0]  cmd_count,
   input  logic [GAP_W-1:0]  cmd_gap,
   input  logic [DATA_W-1:0] cmd_expect,
   input  logic [DATA_W-1:0] cmd_mask,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_mismatch,
   output logic              busy,
   output logic              phi2,
   output logic              extbus_cs_n,
   output logic              extbus_rd_n,
   output logic              extbus_wr_n,
   output logic [ADDR_W-1:0] extbus_a,
   output logic [DATA_W-1:0] extbus_d_out,
   output logic              extbus_d_oe,
   input  logic [DATA_W-1:0] extbus_d_in
);
   localparam int PW = $clog2(2*HALF_PER);
   localparam logic [PW-1:0] P_LAST = PW'(2*HALF_PER-1);
   localparam logic [PW-1:0] P_AH   = PW'(T_AH);
   localparam logic [PW-1:0] P_HI   = PW'(HALF_PER);
   localparam logic [PW-1:0] P_DH   = PW'(HALF_PER+T_AH);

   typedef enum logic [2:0] {IDLE, WAIT_EDGE, LOW, HIGH, GAP} state_t;
   state_t state;

   logic [PW-1:0]     pc, pn;
   logic              rw_n, active, wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data, step, exp_v, mask;
   logic [REP_W-1:0]  cnt;
   logic [GAP_W-1:0]  gap, gcnt;

   always_comb pn = (pc == P_LAST) ? '0 : pc + 1'b1;

   // registered outputs are computed from pn so they are valid while pc holds that value
   always_ff @(posedge clk25) begin
      if (!reset_n) begin
         pc           <= '0;
         phi2         <= 1'b0;
         state        <= IDLE;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_mismatch <= 1'b0;
         extbus_a     <= '0;
         rw_n         <= 1'b1;
         active       <= 1'b0;
         extbus_d_out <= '0;
         extbus_d_oe  <= 1'b0;
         extbus_cs_n  <= 1'b1;
         extbus_rd_n  <= 1'b1;
         extbus_wr_n  <= 1'b1;
         wr           <= 1'b0;
         addr         <= '0;
         data         <= '0;
         step         <= '0;
         exp_v        <= '0;
         mask         <= '0;
         cnt          <= '0;
         gap          <= '0;
         gcnt         <= '0;
      end else begin
         pc          <= pn;
         phi2        <= pn >= P_HI;
         rsp_valid   <= 1'b0;
         extbus_rd_n <= !(active && rw_n && pn >= P_HI);
         extbus_wr_n <= !(active && !rw_n && pn >= P_HI);
         if (pn == P_AH) begin
            if (state == LOW) begin
               extbus_a    <= addr;
               rw_n        <= !wr;
               active      <= 1'b1;
               extbus_cs_n <= (addr & CS_MASK) != CS_BASE;
            end else begin
               extbus_a    <= '0;
               rw_n        <= 1'b1;
               active      <= 1'b0;
               extbus_d_oe <= 1'b0;
               extbus_cs_n <= 1'b1;
            end
         end
         if (state == HIGH && wr && pn == P_DH) begin
            extbus_d_out <= data;
            extbus_d_oe  <= 1'b1;
         end
         case (state)
            IDLE:
               if (cmd_valid && cmd_ready) begin
                  wr        <= cmd_write;
                  addr      <= cmd_addr;
                  data      <= cmd_wdata;
                  step      <= cmd_step;
                  cnt       <= cmd_count;
                  gap       <= cmd_gap;
                  exp_v     <= cmd_expect;
                  mask      <= cmd_mask;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= WAIT_EDGE;
               end else begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            WAIT_EDGE: if (pn == '0) state <= LOW;
            LOW: if (pn == P_HI) state <= HIGH;
            HIGH:
               if (pn == '0) begin
                  rsp_valid    <= 1'b1;
                  rsp_data     <= wr ? data : extbus_d_in;
                  rsp_mismatch <= !wr && (((extbus_d_in ^ exp_v) & mask) != '0);
                  data         <= data + step;
                  gcnt         <= gap;
                  if (cnt == '0) state <= IDLE;
                  else begin
                     cnt   <= cnt - 1'b1;
                     state <= (gap == '0) ? LOW : GAP;
                  end
               end
            GAP:
               if (pn == '0) begin
                  if (gcnt == GAP_W'(1)) state <= LOW;
                  else gcnt <= gcnt - 1'b1;
               end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
